// File: rtl/grid_seq_pkg.sv
// Shared types and default sizes for the grid update sequencer.
// Optional feature macro: GRID_SEQ_IRQ_EN (sticky interrupt output).
package grid_seq_pkg;

   typedef enum logic [1:0] {
      WRITE_CELL = 2'd0,
      FILL_ROW   = 2'd1,
      FILL_COL   = 2'd2,
      CLEAR_ALL  = 2'd3
   } grid_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_e;

   localparam int DEF_GRID_COLS = 16;
   localparam int DEF_GRID_ROWS = 16;
   localparam int DEF_CELL_BITS = 4;

   // True when an 8-bit register field addresses a real row/column.
   function automatic logic idx_in_range(input logic [7:0] idx, input int limit);
      return int'({24'd0, idx}) < limit;
   endfunction

endpackage

// File: rtl/grid_seq_addr_gen.sv
// Row/column cell counters for the grid update sequencer.
// Loaded with the starting cell when a command is accepted, advanced once per
// enabled cycle in the order the operation needs, and flags the final cell.
module grid_seq_addr_gen
   import grid_seq_pkg::*;
#(
   parameter  int GRID_COLS = DEF_GRID_COLS,
   parameter  int GRID_ROWS = DEF_GRID_ROWS,
   localparam int COL_W     = $clog2(GRID_COLS),
   localparam int ROW_W     = $clog2(GRID_ROWS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [ROW_W-1:0] load_row,
   input  logic [COL_W-1:0] load_col,
   input  grid_op_e         op,
   input  logic             en,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last
);

   localparam logic [COL_W-1:0] COL_MAX = COL_W'(GRID_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(GRID_ROWS - 1);

   logic col_at_max;
   logic row_at_max;
   logic [COL_W-1:0] col_next;
   logic [ROW_W-1:0] row_next;

   assign col_at_max = (col == COL_MAX);
   assign row_at_max = (row == ROW_MAX);
   assign col_next   = col_at_max ? '0 : col + COL_W'(1);
   assign row_next   = row_at_max ? '0 : row + ROW_W'(1);

   // Counter update: load the start cell, otherwise step in operation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (load) begin
         row <= load_row;
         col <= load_col;
      end else if (en) begin
         case (op)
            FILL_ROW: col <= col_next;
            FILL_COL: row <= row_next;
            CLEAR_ALL: begin
               col <= col_next;
               if (col_at_max) row <= row_next;
            end
            default: ;
         endcase
      end
   end

   // Final-cell flag for the current operation.
   always_comb begin
      last = 1'b1;
      case (op)
         WRITE_CELL: last = 1'b1;
         FILL_ROW:   last = col_at_max;
         FILL_COL:   last = row_at_max;
         CLEAR_ALL:  last = col_at_max & row_at_max;
         default:    last = 1'b1;
      endcase
   end

endmodule

// File: rtl/grid_update_sequencer.sv
// Grid update sequencer: runs cell/row/column/clear drawing commands into the
// single-port grid RAM, one cell per cycle, yielding the port to the display
// reader whenever it requests it.
// Optional feature macro: GRID_SEQ_IRQ_EN adds a sticky irq with irq_clr.
//
// Command handshake: a command is taken on a rising ACLK edge where
// cmd_valid and cmd_ready are both high; cmd_ready is high only in IDLE, and
// cmd_valid while busy is dropped, never queued. A taken command either pulses
// cmd_err one cycle later (out of range, no writes) or runs and pulses done.
module grid_update_sequencer
   import grid_seq_pkg::*;
#(
   parameter  int GRID_COLS = DEF_GRID_COLS,
   parameter  int GRID_ROWS = DEF_GRID_ROWS,
   parameter  int CELL_BITS = DEF_CELL_BITS,
   localparam int ADDR_W    = $clog2(GRID_ROWS * GRID_COLS),
   localparam int COL_W     = $clog2(GRID_COLS),
   localparam int ROW_W     = $clog2(GRID_ROWS)
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [7:0]           cmd_row,
   input  logic [7:0]           cmd_col,
   input  logic [CELL_BITS-1:0] cmd_value,
   input  logic                 disp_req,
   input  logic [ADDR_W-1:0]    disp_addr,
   output logic                 disp_gnt,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 ram_we,
   output logic [CELL_BITS-1:0] ram_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 cmd_err,
`ifdef GRID_SEQ_IRQ_EN
   output logic                 irq,
   input  logic                 irq_clr,
`endif
   output seq_state_e           state_dbg
);

   seq_state_e           state;
   grid_op_e             op_q;
   grid_op_e             op_in;
   logic [CELL_BITS-1:0] value_q;
   logic                 accept;
   logic                 range_bad;
   logic                 load;
   logic                 step;
   logic                 last;
   logic [ROW_W-1:0]     load_row;
   logic [COL_W-1:0]     load_col;
   logic [ROW_W-1:0]     cur_row;
   logic [COL_W-1:0]     cur_col;
   logic [ADDR_W-1:0]    cell_addr;

   assign op_in     = grid_op_e'(cmd_op);
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign accept    = cmd_valid & cmd_ready;
   assign load      = accept & ~range_bad;
   assign step      = (state == RUN) & ~disp_req;

   // Reject commands whose addressed row/column lies outside the grid.
   always_comb begin
      range_bad = 1'b0;
      case (op_in)
         WRITE_CELL: range_bad = ~idx_in_range(cmd_row, GRID_ROWS) |
                                 ~idx_in_range(cmd_col, GRID_COLS);
         FILL_ROW:   range_bad = ~idx_in_range(cmd_row, GRID_ROWS);
         FILL_COL:   range_bad = ~idx_in_range(cmd_col, GRID_COLS);
         default:    range_bad = 1'b0;
      endcase
   end

   // Starting cell: fills and clears begin at index 0 along the swept axis.
   always_comb begin
      load_row = cmd_row[ROW_W-1:0];
      load_col = cmd_col[COL_W-1:0];
      if (op_in == FILL_COL || op_in == CLEAR_ALL) load_row = '0;
      if (op_in == FILL_ROW || op_in == CLEAR_ALL) load_col = '0;
   end

   grid_seq_addr_gen #(
      .GRID_COLS (GRID_COLS),
      .GRID_ROWS (GRID_ROWS)
   ) u_addr_gen (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .load     (load),
      .load_row (load_row),
      .load_col (load_col),
      .op       (op_q),
      .en       (step),
      .row      (cur_row),
      .col      (cur_col),
      .last     (last)
   );

   assign cell_addr = ADDR_W'(cur_row) * ADDR_W'(GRID_COLS) + ADDR_W'(cur_col);

   // Sequencer FSM with registered done/cmd_err pulses.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state   <= IDLE;
         op_q    <= WRITE_CELL;
         value_q <= '0;
         done    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         done    <= 1'b0;
         cmd_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (range_bad) begin
                     cmd_err <= 1'b1;
                  end else begin
                     state   <= RUN;
                     op_q    <= op_in;
                     value_q <= (op_in == CLEAR_ALL) ? '0 : cmd_value;
                  end
               end
            end
            RUN: begin
               if (step && last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RAM port mux: display owns the port except on sequencer write cycles.
   always_comb begin
      disp_gnt  = disp_req;
      ram_we    = step;
      ram_addr  = step ? cell_addr : disp_addr;
      ram_wdata = value_q;
   end

`ifdef GRID_SEQ_IRQ_EN
   // Sticky interrupt; a new event in the same cycle as a clear keeps it set.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)             irq <= 1'b0;
      else if (done || cmd_err) irq <= 1'b1;
      else if (irq_clr)         irq <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_grid_update_sequencer.sv
// Directed bench for grid_update_sequencer (16x16 grid, 4-bit cells).
// Optional feature macro: GRID_SEQ_IRQ_EN enables the irq checks.
module tb_grid_update_sequencer;
   import grid_seq_pkg::*;

   logic       ACLK;
   logic       ARESETN;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_row;
   logic [7:0] cmd_col;
   logic [3:0] cmd_value;
   logic       disp_req;
   logic [7:0] disp_addr;
   logic       disp_gnt;
   logic [7:0] ram_addr;
   logic       ram_we;
   logic [3:0] ram_wdata;
   logic       busy;
   logic       done;
   logic       cmd_err;
`ifdef GRID_SEQ_IRQ_EN
   logic       irq;
   logic       irq_clr;
`endif
   seq_state_e state_dbg;

   int checks   = 0;
   int failures = 0;

   // Expected write stream: {addr, data}
   logic [11:0] exp_q[$];

   typedef struct {
      logic [1:0] op;
      logic [7:0] row;
      logic [7:0] col;
      logic [3:0] value;
      int         stall_at;
      int         stall_len;
      bit         poke;
      int         exp_writes;
      int         exp_first;
      int         exp_stride;
      logic [3:0] exp_data;
      int         exp_done;
      bit         exp_err;
   } vec_t;

   vec_t vecs[10];

   grid_update_sequencer dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .cmd_value (cmd_value),
      .disp_req  (disp_req),
      .disp_addr (disp_addr),
      .disp_gnt  (disp_gnt),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .busy      (busy),
      .done      (done),
      .cmd_err   (cmd_err),
`ifdef GRID_SEQ_IRQ_EN
      .irq       (irq),
      .irq_clr   (irq_clr),
`endif
      .state_dbg (state_dbg)
   );

   // Clock and watchdog
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] row, input logic [7:0] col,
                               input logic [3:0] value, input int stall_at, input int stall_len,
                               input bit poke, input int exp_writes, input int exp_first,
                               input int exp_stride, input logic [3:0] exp_data,
                               input int exp_done, input bit exp_err);
      vec_t v;
      v.op = op; v.row = row; v.col = col; v.value = value;
      v.stall_at = stall_at; v.stall_len = stall_len; v.poke = poke;
      v.exp_writes = exp_writes; v.exp_first = exp_first; v.exp_stride = exp_stride;
      v.exp_data = exp_data; v.exp_done = exp_done; v.exp_err = exp_err;
      return v;
   endfunction

   // Driver + scoreboard for one command; cycle 1 is the cycle after the accepting edge.
   task automatic run_vec(input vec_t v, input int idx);
      int budget;
      int writes   = 0;
      int done_cyc = 0;
      int done_cnt = 0;
      int err_cyc  = 0;
      int err_cnt  = 0;
      int quiet_bad = 0;
      bit in_stall;
      logic [11:0] w;
      exp_q.delete();
      for (int i = 0; i < v.exp_writes; i++)
         exp_q.push_back({8'(v.exp_first + i * v.exp_stride), v.exp_data});

      @(posedge ACLK); #1;
      check($sformatf("v%0d_ready_before", idx), {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_row = v.row; cmd_col = v.col; cmd_value = v.value;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0;
      budget = v.exp_err ? 6 : v.exp_writes + v.stall_len + 8;
      for (int c = 1; c <= budget; c++) begin
         in_stall  = (v.stall_len > 0) && (c >= v.stall_at) && (c < v.stall_at + v.stall_len);
         disp_req  = in_stall;
         disp_addr = 8'(c * 7 + 3);
         if (v.poke && (c == 5 || c == 6)) begin
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_row = 8'd1; cmd_col = 8'd1; cmd_value = 4'h7;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge ACLK);
         if (c == 1) begin
            check($sformatf("v%0d_busy_c1", idx), {31'd0, busy}, v.exp_err ? 32'd0 : 32'd1);
            check($sformatf("v%0d_ready_c1", idx), {31'd0, cmd_ready}, v.exp_err ? 32'd1 : 32'd0);
         end
         if (v.poke && c == 5)
            check($sformatf("v%0d_ready_poke", idx), {31'd0, cmd_ready}, 32'd0);
         if (in_stall) begin
            check($sformatf("v%0d_stall_we", idx), {31'd0, ram_we}, 32'd0);
            check($sformatf("v%0d_stall_addr", idx), {24'd0, ram_addr}, {24'd0, disp_addr});
            check($sformatf("v%0d_stall_gnt", idx), {31'd0, disp_gnt}, 32'd1);
         end
         if (ram_we) begin
            writes++;
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               check($sformatf("v%0d_wr%0d_addr", idx, writes), {24'd0, ram_addr}, {24'd0, w[11:4]});
               check($sformatf("v%0d_wr%0d_data", idx, writes), {28'd0, ram_wdata}, {28'd0, w[3:0]});
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (cmd_err) begin
            err_cnt++;
            if (err_cyc == 0) err_cyc = c;
         end
         if (done_cyc != 0) break;
         @(posedge ACLK); #1;
      end
      disp_req  = 1'b0;
      cmd_valid = 1'b0;
      for (int q = 0; q < 3; q++) begin
         @(posedge ACLK); #1;
         @(negedge ACLK);
         if (ram_we || done || cmd_err || busy || !cmd_ready) quiet_bad++;
      end
      check($sformatf("v%0d_write_count", idx), writes, v.exp_writes);
      check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
      check($sformatf("v%0d_done_count", idx), done_cnt, (v.exp_done != 0) ? 1 : 0);
      check($sformatf("v%0d_err_cycle", idx), err_cyc, v.exp_err ? 1 : 0);
      check($sformatf("v%0d_err_count", idx), err_cnt, v.exp_err ? 1 : 0);
      check($sformatf("v%0d_quiet_after", idx), quiet_bad, 0);
   endtask

   initial begin
      int bad;
      // Vector table: op, row, col, value, stall_at, stall_len, poke,
      //               writes, first addr, stride, data, done cycle, err
      vecs[0] = mk(2'd0, 8'd2,   8'd3,   4'h5, 0,  0, 1'b0, 1,   'h23, 0,  4'h5, 2,   1'b0);
      vecs[1] = mk(2'd1, 8'd4,   8'd0,   4'hA, 5,  3, 1'b0, 16,  'h40, 1,  4'hA, 20,  1'b0);
      vecs[2] = mk(2'd2, 8'd0,   8'd7,   4'h3, 0,  0, 1'b0, 16,  'h07, 16, 4'h3, 17,  1'b0);
      vecs[3] = mk(2'd3, 8'd0,   8'd0,   4'hF, 0,  0, 1'b1, 256, 'h00, 1,  4'h0, 257, 1'b0);
      vecs[4] = mk(2'd0, 8'd16,  8'd0,   4'h1, 0,  0, 1'b0, 0,   0,    0,  4'h0, 0,   1'b1);
      vecs[5] = mk(2'd2, 8'd0,   8'd16,  4'h2, 0,  0, 1'b0, 0,   0,    0,  4'h0, 0,   1'b1);
      vecs[6] = mk(2'd1, 8'd15,  8'd200, 4'h9, 0,  0, 1'b0, 16,  'hF0, 1,  4'h9, 17,  1'b0);
      vecs[7] = mk(2'd0, 8'd15,  8'd15,  4'hC, 1,  2, 1'b0, 1,   'hFF, 0,  4'hC, 4,   1'b0);
      vecs[8] = mk(2'd2, 8'd99,  8'd0,   4'hE, 16, 1, 1'b0, 16,  'h00, 16, 4'hE, 18,  1'b0);
      vecs[9] = mk(2'd0, 8'd3,   8'd255, 4'h4, 0,  0, 1'b0, 0,   0,    0,  4'h0, 0,   1'b1);

      // Reset block
      ARESETN = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row = 8'd0; cmd_col = 8'd0;
      cmd_value = 4'h0; disp_req = 1'b0; disp_addr = 8'h5A;
`ifdef GRID_SEQ_IRQ_EN
      irq_clr = 1'b0;
`endif
      #53;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, cmd_err}, 32'd0);
      check("rst_we", {31'd0, ram_we}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_addr_a", {24'd0, ram_addr}, 32'h5A);
      disp_addr = 8'hC3;
      #50;
      check("rst_addr_b", {24'd0, ram_addr}, 32'hC3);
`ifdef GRID_SEQ_IRQ_EN
      check("rst_irq", {31'd0, irq}, 32'd0);
`endif
      #97;
      ARESETN = 1'b1;
      repeat (2) @(posedge ACLK);

      for (int i = 0; i < 10; i++) begin
`ifdef GRID_SEQ_IRQ_EN
         if (vecs[i].exp_err) begin
            @(posedge ACLK); #1; irq_clr = 1'b1;
            @(posedge ACLK); #1; irq_clr = 1'b0;
            @(negedge ACLK);
            check($sformatf("v%0d_irq_pre_clear", i), {31'd0, irq}, 32'd0);
         end
`endif
         run_vec(vecs[i], i);
`ifdef GRID_SEQ_IRQ_EN
         check($sformatf("v%0d_irq_set", i), {31'd0, irq}, 32'd1);
`endif
      end

      // Abort: reset asserted in the middle of a CLEAR_ALL
      @(posedge ACLK); #1;
      cmd_valid = 1'b1; cmd_op = 2'd3; cmd_row = 8'd0; cmd_col = 8'd0; cmd_value = 4'h6;
      @(posedge ACLK); #1;
      cmd_valid = 1'b0; disp_addr = 8'h3C;
      repeat (20) @(posedge ACLK);
      #2;
      check("abort_running", {31'd0, ram_we}, 32'd1);
      ARESETN = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_we", {31'd0, ram_we}, 32'd0);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_addr", {24'd0, ram_addr}, 32'h3C);
      #20;
      ARESETN = 1'b1;
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge ACLK);
         if (ram_we || done || busy) bad++;
      end
      check("abort_no_resume", bad, 0);

      // Recovery after abort
      run_vec(vecs[0], 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
